// File: rtl/if_tracker.sv
// rtl/if_tracker.sv - IF-stage trace producer: builds one trace element per completed fetch and queues it for the ID tracker.
package if_tracker_pkg;
  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
  } stage_time_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instruction;
    stage_time_t if_data;
    stage_time_t id_data;
    stage_time_t ex_data;
    stage_time_t wb_data;
    logic [31:0] pass_through;
  } trace_output;
endpackage

module if_tracker
  import if_tracker_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           counter,
  input  logic                  instr_req,
  input  logic                  instr_gnt,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_rvalid,
  input  logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic                  if_flush,
  input  logic                  id_ready,
  output logic                  if_data_ready,
  output trace_output           if_data_out,
  output logic                  overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, DISCARD} state_t;

  state_t            r_state;
  state_t            w_next_state;
  trace_output       r_build;
  trace_output       w_elem;
  trace_output       r_out;
  trace_output       w_next_head;
  trace_output       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_rd_next;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              w_capture;
  logic              w_done;
  logic              w_pop;
  logic              w_full;
  logic              w_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Flush during WAIT_RVALID still owes us one rvalid, which DISCARD swallows.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_req) begin
          w_capture    = 1'b1;
          w_next_state = instr_gnt ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (if_flush)       w_next_state = IDLE;
        else if (instr_gnt) w_next_state = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (instr_rvalid) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end else if (if_flush) begin
          w_next_state = DISCARD;
        end
      end
      DISCARD: begin
        if (instr_rvalid) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_elem                    = r_build;
    w_elem.instruction        = 32'(instr_rdata);
    w_elem.if_data.time_end   = counter;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_build <= '0;
    end else if (w_capture) begin
      r_build                    <= '0;
      r_build.addr               <= 32'(instr_addr);
      r_build.if_data.time_start <= counter;
    end else if (w_done) begin
      r_build <= w_elem;
    end
  end

  assign w_pop     = (r_count != '0) && id_ready;
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_write   = w_done && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + PTR_W'(1);

  // Registered head: look ahead to whatever will sit at the head after this edge.
  always_comb begin
    w_next_head = r_out;
    if (w_pop) begin
      if (r_count > CNT_W'(1)) w_next_head = r_mem[w_rd_next];
      else if (w_write)        w_next_head = w_elem;
    end else if (r_count == '0 && w_write) begin
      w_next_head = w_elem;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_elem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_out <= w_next_head;
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= w_rd_next;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_done && !w_write) r_overflow <= 1'b1;
    end
  end

  assign if_data_ready = (r_count != '0);
  assign if_data_out   = r_out;
  assign overflow      = r_overflow;
endmodule

// File: tb/tb_if_tracker.sv
// tb/tb_if_tracker.sv - directed self-checking bench for if_tracker.
module tb_if_tracker;
  import if_tracker_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] counter;
  logic        instr_req;
  logic        instr_gnt;
  logic [31:0] instr_addr;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        if_flush;
  logic        id_ready;
  logic        if_data_ready;
  trace_output if_data_out;
  logic        overflow;

  int passes = 0;
  int total  = 0;

  if_tracker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .counter       (counter),
    .instr_req     (instr_req),
    .instr_gnt     (instr_gnt),
    .instr_addr    (instr_addr),
    .instr_rvalid  (instr_rvalid),
    .instr_rdata   (instr_rdata),
    .if_flush      (if_flush),
    .id_ready      (id_ready),
    .if_data_ready (if_data_ready),
    .if_data_out   (if_data_out),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    counter = counter + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic trace_output mk(input logic [31:0] a, input logic [31:0] d,
                                     input logic [31:0] ts, input logic [31:0] te);
    trace_output t;
    t = '0;
    t.addr               = a;
    t.instruction        = d;
    t.if_data.time_start = ts;
    t.if_data.time_end   = te;
    return t;
  endfunction

  // req+gnt on one edge, rvalid on the next; id_ready takes rdy for the completing edge.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic rdy,
                       output trace_output e);
    logic [31:0] ts;
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = a;
    ts = counter;
    tick();
    instr_req = 1'b0; instr_gnt = 1'b0;
    instr_rvalid = 1'b1; instr_rdata = d; id_ready = rdy;
    e = mk(a, d, ts, counter);
    tick();
    instr_rvalid = 1'b0;
  endtask

  trace_output e1, e2, e3;

  initial begin
    rst = 1'b0; counter = 32'd0; instr_req = 1'b0; instr_gnt = 1'b0;
    instr_addr = '0; instr_rvalid = 1'b0; instr_rdata = '0; if_flush = 1'b0; id_ready = 1'b0;
    tick(); tick();
    chk("reset_ready", 512'(if_data_ready), 512'(0));
    chk("reset_overflow", 512'(overflow), 512'(0));
    chk("reset_data", 512'(if_data_out), 512'(0));
    rst = 1'b1;
    tick();

    // Single fetch
    counter = 32'd10; id_ready = 1'b1;
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h80;
    tick();
    instr_req = 1'b0; instr_gnt = 1'b0;
    chk("single_not_yet", 512'(if_data_ready), 512'(0));
    tick();
    instr_rvalid = 1'b1; instr_rdata = 32'h00A00093;
    tick();
    instr_rvalid = 1'b0;
    chk("single_ready", 512'(if_data_ready), 512'(1));
    chk("single_data", 512'(if_data_out), 512'(mk(32'h80, 32'h00A00093, 32'd10, 32'd12)));
    tick();
    chk("single_one_cycle", 512'(if_data_ready), 512'(0));
    chk("single_hold_last", 512'(if_data_out), 512'(mk(32'h80, 32'h00A00093, 32'd10, 32'd12)));

    // Delayed grant
    counter = 32'd20;
    instr_req = 1'b1; instr_addr = 32'h84;
    tick();
    instr_req = 1'b0;
    tick(); tick();
    instr_gnt = 1'b1;
    tick();
    instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h11;
    tick();
    instr_rvalid = 1'b0;
    chk("dgnt_ready", 512'(if_data_ready), 512'(1));
    chk("dgnt_data", 512'(if_data_out), 512'(mk(32'h84, 32'h11, 32'd20, 32'd24)));
    tick();

    // Flush while waiting for rvalid
    counter = 32'd30;
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h88;
    tick();
    instr_req = 1'b0; instr_gnt = 1'b0; if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    tick();
    instr_rvalid = 1'b1; instr_rdata = 32'hDEAD;
    tick();
    instr_rvalid = 1'b0;
    chk("flush_dropped", 512'(if_data_ready), 512'(0));
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h8C;
    tick();
    instr_req = 1'b0; instr_gnt = 1'b0; instr_rvalid = 1'b1; instr_rdata = 32'h22;
    tick();
    instr_rvalid = 1'b0;
    chk("flush_next_ready", 512'(if_data_ready), 512'(1));
    chk("flush_next_data", 512'(if_data_out), 512'(mk(32'h8C, 32'h22, 32'd34, 32'd35)));
    tick();

    // Backpressure and overflow
    id_ready = 1'b0;
    fetch(32'h100, 32'hA1, 1'b0, e1);
    chk("bp_first_ready", 512'(if_data_ready), 512'(1));
    chk("bp_first_data", 512'(if_data_out), 512'(e1));
    fetch(32'h104, 32'hA2, 1'b0, e2);
    chk("bp_stable", 512'(if_data_out), 512'(e1));
    chk("bp_no_ovf_yet", 512'(overflow), 512'(0));
    fetch(32'h108, 32'hA3, 1'b0, e3);
    chk("bp_overflow", 512'(overflow), 512'(1));
    chk("bp_still_first", 512'(if_data_out), 512'(e1));
    id_ready = 1'b1;
    tick();
    chk("bp_second_ready", 512'(if_data_ready), 512'(1));
    chk("bp_second_data", 512'(if_data_out), 512'(e2));
    tick();
    chk("bp_drained", 512'(if_data_ready), 512'(0));
    chk("bp_ovf_sticky", 512'(overflow), 512'(1));

    rst = 1'b0; #2; rst = 1'b1;
    chk("ovf_cleared", 512'(overflow), 512'(0));

    // Full-queue push and pop on the same edge
    id_ready = 1'b0;
    fetch(32'h200, 32'hB1, 1'b0, e1);
    fetch(32'h204, 32'hB2, 1'b0, e2);
    fetch(32'h208, 32'hB3, 1'b1, e3);
    chk("pp_ready", 512'(if_data_ready), 512'(1));
    chk("pp_head_second", 512'(if_data_out), 512'(e2));
    chk("pp_no_overflow", 512'(overflow), 512'(0));
    tick();
    chk("pp_third_ready", 512'(if_data_ready), 512'(1));
    chk("pp_third_data", 512'(if_data_out), 512'(e3));
    tick();
    chk("pp_drained", 512'(if_data_ready), 512'(0));

    // Asynchronous reset mid-fetch with one queued element
    id_ready = 1'b0;
    fetch(32'h300, 32'hC1, 1'b0, e1);
    chk("ar_queued", 512'(if_data_ready), 512'(1));
    instr_req = 1'b1; instr_gnt = 1'b1; instr_addr = 32'h304;
    tick();
    instr_req = 1'b0; instr_gnt = 1'b0;
    #2; rst = 1'b0; #1;
    chk("ar_ready_now", 512'(if_data_ready), 512'(0));
    chk("ar_ovf_now", 512'(overflow), 512'(0));
    chk("ar_data_now", 512'(if_data_out), 512'(0));
    #1; rst = 1'b1;
    instr_rvalid = 1'b1; instr_rdata = 32'hC2; id_ready = 1'b1;
    tick();
    instr_rvalid = 1'b0;
    tick();
    chk("ar_spurious_ignored", 512'(if_data_ready), 512'(0));
    chk("ar_data_untouched", 512'(if_data_out), 512'(0));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
